requant_pack: RTL and testbench

Downstream consumer of the bias-add stage in the convolution datapath. It accepts the signed per-output accumulator-plus-bias stream one element per handshake. Each element gets a per-element rounding right-shift, an optional ReLU, and saturation to a signed activation width. Results are packed into COLS-lane words and handed to the activation write-back over a valid/ready interface.

---
 rtl/accel_pkg.sv | 19 +
 rtl/requant_pack_if.sv | 33 +++
 rtl/requant_pack_lane.sv | 41 ++++
 rtl/requant_pack.sv | 129 ++++++++++++
 tb/tb_requant_pack.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: default widths, FSM state encoding and saturation bounds for the requant stage
package accel_pkg;

   localparam int DEF_COLS     = 5;
   localparam int DEF_AB_BW    = 25;
   localparam int DEF_O_BW     = 8;
   localparam int DEF_SHIFT_BW = 5;

   typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_e;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/requant_pack_if.sv
// requant_pack_if: element stream from bias-add in, packed activation words out
interface requant_pack_if import accel_pkg::*; #(
   parameter int COLS     = DEF_COLS,
   parameter int AB_BW    = DEF_AB_BW,
   parameter int O_BW     = DEF_O_BW,
   parameter int SHIFT_BW = DEF_SHIFT_BW
) ();

   localparam int CBW = $clog2(COLS + 1);

   logic                    i_valid;
   logic                    o_ready;
   logic signed [AB_BW-1:0] i_acc_bias;
   logic [SHIFT_BW-1:0]     i_shift;
   logic                    i_relu_en;
   logic                    i_last;
   logic                    o_valid;
   logic                    i_ready;
   logic [COLS*O_BW-1:0]    o_data;
   logic [CBW-1:0]          o_count;
   logic                    o_last;

   modport master (
      output i_valid, i_acc_bias, i_shift, i_relu_en, i_last, i_ready,
      input  o_ready, o_valid, o_data, o_count, o_last
   );

   modport slave (
      input  i_valid, i_acc_bias, i_shift, i_relu_en, i_last, i_ready,
      output o_ready, o_valid, o_data, o_count, o_last
   );

endinterface

// File: rtl/requant_pack_lane.sv
// requant_lane: clamp shift, round half toward +inf, optional ReLU, saturate, then register
module requant_lane import accel_pkg::*; #(
   parameter int AB_BW    = DEF_AB_BW,
   parameter int O_BW     = DEF_O_BW,
   parameter int SHIFT_BW = DEF_SHIFT_BW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [AB_BW-1:0] x_i,
   input  logic [SHIFT_BW-1:0]     shift_i,
   input  logic                    relu_i,
   output logic signed [O_BW-1:0]  q_o
);

   localparam int CW = $clog2(AB_BW);
   localparam logic signed [AB_BW:0] MAXV = (AB_BW + 1)'(sat_max(O_BW));
   localparam logic signed [AB_BW:0] MINV = (AB_BW + 1)'(sat_min(O_BW));

   logic [CW-1:0]          s;
   logic signed [AB_BW:0]  xe, rnd, r, rr;
   logic signed [O_BW-1:0] q_d, q_q;

   // one extra bit of headroom keeps the rounding add from overflowing
   always_comb begin
      s   = (32'(shift_i) > 32'(AB_BW - 1)) ? CW'(AB_BW - 1) : CW'(shift_i);
      xe  = {x_i[AB_BW-1], x_i};
      rnd = (s == '0) ? '0 : (AB_BW + 1)'(1) << (s - CW'(1));
      r   = (xe + rnd) >>> s;
      rr  = (relu_i && r[AB_BW]) ? '0 : r;
      q_d = (rr > MAXV) ? MAXV[O_BW-1:0] : (rr < MINV) ? MINV[O_BW-1:0] : rr[O_BW-1:0];
   end

   // quantized value register (second pipeline stage)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/requant_pack.sv
// requant_pack: requantizes bias-added accumulators and packs them into COLS-lane words
module requant_pack import accel_pkg::*; #(
   parameter int COLS     = DEF_COLS,
   parameter int AB_BW    = DEF_AB_BW,
   parameter int O_BW     = DEF_O_BW,
   parameter int SHIFT_BW = DEF_SHIFT_BW
) (
   input  logic           clk,
   input  logic           rst_n,
   requant_pack_if.slave  bus
);

   localparam int CBW = $clog2(COLS + 1);

   state_e                  state_q, state_d;
   logic                    acc, close_now, hs;
   logic                    v0_q, relu0_q, last0_q, close0_q;
   logic signed [AB_BW-1:0] x0_q;
   logic [SHIFT_BW-1:0]     s0_q;
   logic                    v1_q, last1_q, close1_q;
   logic signed [O_BW-1:0]  q1;
   logic [COLS*O_BW-1:0]    pack_q, pack_d;
   logic [CBW-1:0]          lane_q, lane_d, cnt_q, cnt_d;
   logic                    last_q, last_d;

   assign acc       = bus.i_valid && state_q == FILL;
   assign close_now = bus.i_last || cnt_q == CBW'(COLS - 1);
   assign hs        = state_q == EMIT && bus.i_ready;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   // next state: the word drains until its closing element lands in the pack buffer
   always_comb begin
      state_d = (state_q == FILL)  ? ((acc && close_now) ? DRAIN : FILL) :
                (state_q == DRAIN) ? ((v1_q && close1_q) ? EMIT : DRAIN) :
                (bus.i_ready ? FILL : EMIT);
   end

   // handshake outputs decoded from state
   always_comb begin
      bus.o_ready = state_q == FILL;
      bus.o_valid = state_q == EMIT;
   end

   // capture accepted element and carry its flags alongside the quantizer stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q     <= 1'b0;
         x0_q     <= '0;
         s0_q     <= '0;
         relu0_q  <= 1'b0;
         last0_q  <= 1'b0;
         close0_q <= 1'b0;
         v1_q     <= 1'b0;
         last1_q  <= 1'b0;
         close1_q <= 1'b0;
      end else begin
         v0_q <= acc;
         if (acc) begin
            x0_q     <= bus.i_acc_bias;
            s0_q     <= bus.i_shift;
            relu0_q  <= bus.i_relu_en;
            last0_q  <= bus.i_last;
            close0_q <= close_now;
         end
         v1_q     <= v0_q;
         last1_q  <= last0_q;
         close1_q <= close0_q;
      end
   end

   requant_lane #(
      .AB_BW    (AB_BW),
      .O_BW     (O_BW),
      .SHIFT_BW (SHIFT_BW)
   ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .x_i     (x0_q),
      .shift_i (s0_q),
      .relu_i  (relu0_q),
      .q_o     (q1)
   );

   // pack buffer update: lane writes as quantized values arrive, cleared by the output handshake
   always_comb begin
      pack_d = pack_q;
      lane_d = lane_q;
      cnt_d  = cnt_q;
      last_d = last_q;
      if (hs) begin
         pack_d = '0;
         lane_d = '0;
         cnt_d  = '0;
         last_d = 1'b0;
      end else begin
         if (acc) cnt_d = cnt_q + CBW'(1);
         if (v1_q) begin
            pack_d[lane_q*O_BW +: O_BW] = q1;
            lane_d = lane_q + CBW'(1);
            last_d = last1_q;
         end
      end
   end

   // pack buffer and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_q <= '0;
         lane_q <= '0;
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         pack_q <= pack_d;
         lane_q <= lane_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign bus.o_data  = pack_q;
   assign bus.o_count = lane_q;
   assign bus.o_last  = last_q;

endmodule

// File: tb/tb_requant_pack.sv
// tb_requant_pack: table-driven and random stimulus against a word scoreboard
module tb_requant_pack;

   localparam int COLS = 5, AB_BW = 25, O_BW = 8, SHIFT_BW = 5;
   localparam int CBW = $clog2(COLS + 1);

   typedef struct {
      logic signed [AB_BW-1:0] x;
      logic [SHIFT_BW-1:0]     s;
      logic                    relu;
      logic                    last;
      logic signed [O_BW-1:0]  lane;
   } vec_t;

   typedef struct {
      logic [COLS*O_BW-1:0] data;
      logic [CBW-1:0]       cnt;
      logic                 last;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   word_t sb[$];
   logic [COLS*O_BW-1:0] cur_data = '0;
   int cur_cnt = 0;
   vec_t tbl[9];

   always #5 clk = ~clk;

   requant_pack_if #(.COLS(COLS), .AB_BW(AB_BW), .O_BW(O_BW), .SHIFT_BW(SHIFT_BW)) bus ();

   requant_pack #(.COLS(COLS), .AB_BW(AB_BW), .O_BW(O_BW), .SHIFT_BW(SHIFT_BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic signed [O_BW-1:0] model(input logic signed [AB_BW-1:0] x, input int s, input bit relu);
      int  sc;
      real r;
      sc = (s > AB_BW - 1) ? AB_BW - 1 : s;
      r  = (sc == 0) ? real'(x) : $floor((real'(x) + 2.0 ** (sc - 1)) / 2.0 ** sc);
      if (relu && r < 0.0) r = 0.0;
      if (r > 2.0 ** (O_BW - 1) - 1.0) r = 2.0 ** (O_BW - 1) - 1.0;
      if (r < -(2.0 ** (O_BW - 1))) r = -(2.0 ** (O_BW - 1));
      return O_BW'($rtoi(r));
   endfunction

   function automatic vec_t rnd_vec(input bit last);
      vec_t v;
      if ($urandom_range(0, 1) == 1) begin
         v.x = AB_BW'(int'($urandom_range(0, 4000)) - 2000);
         v.s = SHIFT_BW'($urandom_range(0, 4));
      end else begin
         v.x = AB_BW'($urandom);
         v.s = SHIFT_BW'($urandom_range(10, 31));
      end
      v.relu = 1'($urandom_range(0, 1));
      v.last = last;
      v.lane = model(v.x, int'(v.s), v.relu);
      return v;
   endfunction

   // entered and left 1 time unit after a rising edge; holds the element until accepted
   task automatic send(input vec_t v, input int gap);
      int n = 0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.i_valid    = 1'b1;
      bus.i_acc_bias = v.x;
      bus.i_shift    = v.s;
      bus.i_relu_en  = v.relu;
      bus.i_last     = v.last;
      while (!bus.o_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!bus.o_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: o_ready=0 after %0d cycles, want 1", n);
      end else begin
         @(posedge clk);
         cur_data[cur_cnt*O_BW +: O_BW] = v.lane;
         cur_cnt++;
         if (cur_cnt == COLS || v.last) begin
            sb.push_back('{cur_data, CBW'(cur_cnt), v.last});
            cur_data = '0;
            cur_cnt  = 0;
         end
         #1;
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d words still pending, want 0", name, sb.size());
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got data 0x%0h, want no word", bus.o_data);
         end else begin
            word_t w;
            w = sb.pop_front();
            check("word_data", bus.o_data, w.data);
            check("word_count", bus.o_count, w.cnt);
            check("word_last", bus.o_last, w.last);
         end
      end
   end

   initial begin
      tbl[0] = '{25'sd300, 5'd2, 1'b0, 1'b0, 8'sd75};
      tbl[1] = '{-25'sd6, 5'd2, 1'b0, 1'b0, -8'sd1};
      tbl[2] = '{25'sd1000, 5'd2, 1'b0, 1'b0, 8'sd127};
      tbl[3] = '{-25'sd1000, 5'd0, 1'b0, 1'b0, 8'h80};
      tbl[4] = '{25'sd0, 5'd0, 1'b0, 1'b0, 8'sd0};
      tbl[5] = '{-25'sd1000, 5'd0, 1'b1, 1'b0, 8'sd0};
      tbl[6] = '{25'sd7, 5'd1, 1'b1, 1'b1, 8'sd4};
      tbl[7] = '{25'sh0FFFFFF, 5'd31, 1'b0, 1'b0, 8'sd1};
      tbl[8] = '{25'sh1000000, 5'd24, 1'b0, 1'b1, 8'hFF};
      bus.i_valid    = 1'b0;
      bus.i_acc_bias = '0;
      bus.i_shift    = '0;
      bus.i_relu_en  = 1'b0;
      bus.i_last     = 1'b0;
      bus.i_ready    = 1'b1;
      #2;
      check("rst_valid", bus.o_valid, 1'b0);
      check("rst_data", bus.o_data, '0);
      check("rst_count", bus.o_count, '0);
      check("rst_last", bus.o_last, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", bus.o_ready, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send(tbl[i], 0);
      check("drain_ready", bus.o_ready, 1'b0);
      @(negedge clk); check("lat_0", bus.o_valid, 1'b0);
      @(negedge clk); check("lat_1", bus.o_valid, 1'b0);
      @(negedge clk); check("lat_2", bus.o_valid, 1'b1);
      @(posedge clk); #1;
      check("ready_after_hs", bus.o_ready, 1'b1);
      for (int i = 5; i < 7; i++) send(tbl[i], 0);
      wait_empty("relu_word");
      bus.i_ready = 1'b0;
      for (int i = 7; i < 9; i++) send(tbl[i], 0);
      begin
         int n = 0;
         while (!bus.o_valid && n < 20) begin @(negedge clk); n++; end
      end
      check("bp_valid", bus.o_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", {bus.o_valid, bus.o_ready, bus.o_count, bus.o_last, bus.o_data},
               {1'b1, 1'b0, 3'd2, 1'b1, 40'h00000_0FF01});
      end
      @(posedge clk); #1;
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      @(negedge clk);
      check("bp_release", {bus.o_ready, bus.o_valid}, 2'b10);
      @(posedge clk); #1;
      bus.i_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(tbl[i], 0);
      rst_n = 1'b0;
      cur_data = '0;
      cur_cnt = 0;
      #1;
      check("mid_rst", {bus.o_valid, bus.o_count, bus.o_last, bus.o_data}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", {bus.o_ready, bus.o_valid, bus.o_count}, {1'b1, 1'b0, 3'd0});
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send(tbl[i], 0);
      wait_empty("fresh_word");
      for (int i = 0; i < 24; i++) send(rnd_vec((i == 23) ? 1'b1 : ($urandom_range(0, 4) == 0)), i % 2);
      wait_empty("final_drain");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
